// File: rtl/prbs_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
// Shared definitions for the 16-bit Fibonacci PRBS generator and checker.
//   PRBS_W          : stream word width
//   TAP_HI / TAP_LO : feedback tap positions
//   lfsr_next()     : one-step LFSR advance, next = {cur[14:0], cur[15]^cur[14]}
//   checker_state_t : HUNT / LOCKED state encoding of the checker
// -----------------------------------------------------------------------------
package prbs_pkg;

   localparam int PRBS_W = 16;
   localparam int TAP_HI = 15;
   localparam int TAP_LO = 14;

   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } checker_state_t;

   // Advance the LFSR by one word; purely combinational.
   function automatic logic [PRBS_W-1:0] lfsr_next(input logic [PRBS_W-1:0] word);
      return {word[PRBS_W-2:0], word[TAP_HI] ^ word[TAP_LO]};
   endfunction

endpackage

// File: rtl/prbs_popcount16.sv
// -----------------------------------------------------------------------------
// prbs_popcount16
// Combinational population count of a 16-bit word.
//   data_i  : input word
//   count_o : number of set bits in data_i (0..16)
// -----------------------------------------------------------------------------
module prbs_popcount16 (
   input  logic [15:0] data_i,
   output logic [4:0]  count_o
);

   // Sum the individual bits.
   always_comb begin
      count_o = 5'd0;
      for (int i = 0; i < 16; i++) begin
         count_o = count_o + {4'd0, data_i[i]};
      end
   end

endmodule

// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
// Receive-side checker for the 16-bit Fibonacci PRBS stream. In HUNT it seeds
// its reference from incoming words until LOCK_CNT consecutive words are
// predicted correctly; in LOCKED it free-runs its own prediction (flywheel),
// flags and counts every mismatching word, and drops back to HUNT after
// UNLOCK_CNT consecutive mismatches.
//
// Ports:
//   clk             : rising-edge clock
//   reset           : synchronous, active-high reset
//   data_valid      : data_in carries a stream word this cycle
//   data_in         : received LFSR word
//   clear_counts    : synchronous clear of the error counters (wins over +1)
//   locked          : checker is locked to the stream
//   error_flag      : one-cycle pulse, previous valid word mismatched in LOCKED
//   error_count     : saturating count of mismatched words in LOCKED
//   bit_error_count : saturating count of mismatched bits in LOCKED
//                     (present only when PRBS_CHECKER_BITERR_EN is defined)
//
// Optional feature macro: PRBS_CHECKER_BITERR_EN
// -----------------------------------------------------------------------------
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 8,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              data_valid,
   input  logic [PRBS_W-1:0] data_in,
   input  logic              clear_counts,
   output logic              locked,
   output logic              error_flag,
   output logic [CNT_W-1:0]  error_count
`ifdef PRBS_CHECKER_BITERR_EN
   ,
   output logic [CNT_W+3:0]  bit_error_count
`endif
);

   localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

   checker_state_t    state_q, state_d;
   logic [PRBS_W-1:0] ref_q, ref_d;
   logic              ref_valid_q, ref_valid_d;
   logic [3:0]        match_run_q, match_run_d;
   logic [3:0]        miss_run_q, miss_run_d;
   logic              locked_q, locked_d;
   logic              error_flag_q, error_flag_d;
   logic [CNT_W-1:0]  error_count_q, error_count_d;

   logic [PRBS_W-1:0] expected_s;
   logic              mismatch_s;
   logic [3:0]        match_inc_s;
   logic [3:0]        miss_inc_s;
   logic              err_inc_s;
   logic              locked_beat_s;

   assign expected_s  = lfsr_next(ref_q);
   assign mismatch_s  = (data_in != expected_s);
   assign match_inc_s = match_run_q + 4'd1;
   assign miss_inc_s  = miss_run_q + 4'd1;

   // Next-state logic for the HUNT/LOCKED machine, reference and run counters.
   always_comb begin
      state_d       = state_q;
      ref_d         = ref_q;
      ref_valid_d   = ref_valid_q;
      match_run_d   = match_run_q;
      miss_run_d    = miss_run_q;
      locked_d      = locked_q;
      error_flag_d  = 1'b0;
      err_inc_s     = 1'b0;
      locked_beat_s = 1'b0;
      if (data_valid) begin
         case (state_q)
            HUNT: begin
               if (data_in == {PRBS_W{1'b0}}) begin
                  // All-zero is not a reachable LFSR state: restart seeding.
                  ref_valid_d = 1'b0;
                  match_run_d = 4'd0;
               end else begin
                  ref_d       = data_in;
                  ref_valid_d = 1'b1;
                  if (ref_valid_q && !mismatch_s) begin
                     match_run_d = match_inc_s;
                     if (match_inc_s == LOCK_C) begin
                        state_d    = LOCKED;
                        miss_run_d = 4'd0;
                        locked_d   = 1'b1;
                     end else begin
                        state_d = HUNT;
                     end
                  end else begin
                     match_run_d = 4'd0;
                  end
               end
            end
            LOCKED: begin
               // Flywheel: the reference only advances on its own prediction.
               locked_beat_s = 1'b1;
               ref_d         = expected_s;
               if (mismatch_s) begin
                  error_flag_d = 1'b1;
                  err_inc_s    = 1'b1;
                  miss_run_d   = miss_inc_s;
                  if (miss_inc_s == UNLOCK_C) begin
                     state_d     = HUNT;
                     ref_valid_d = 1'b0;
                     match_run_d = 4'd0;
                     locked_d    = 1'b0;
                  end else begin
                     state_d = LOCKED;
                  end
               end else begin
                  miss_run_d = 4'd0;
               end
            end
            default: begin
               state_d     = HUNT;
               ref_valid_d = 1'b0;
               match_run_d = 4'd0;
               locked_d    = 1'b0;
            end
         endcase
      end else begin
         error_flag_d = 1'b0;
      end
   end

   // Word error counter: clear wins over increment, saturates at all-ones.
   always_comb begin
      error_count_d = error_count_q;
      if (clear_counts) begin
         error_count_d = {CNT_W{1'b0}};
      end else if (err_inc_s && !(&error_count_q)) begin
         error_count_d = error_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         error_count_d = error_count_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= HUNT;
         ref_q         <= {PRBS_W{1'b0}};
         ref_valid_q   <= 1'b0;
         match_run_q   <= 4'd0;
         miss_run_q    <= 4'd0;
         locked_q      <= 1'b0;
         error_flag_q  <= 1'b0;
         error_count_q <= {CNT_W{1'b0}};
      end else begin
         state_q       <= state_d;
         ref_q         <= ref_d;
         ref_valid_q   <= ref_valid_d;
         match_run_q   <= match_run_d;
         miss_run_q    <= miss_run_d;
         locked_q      <= locked_d;
         error_flag_q  <= error_flag_d;
         error_count_q <= error_count_d;
      end
   end

   assign locked      = locked_q;
   assign error_flag  = error_flag_q;
   assign error_count = error_count_q;

`ifdef PRBS_CHECKER_BITERR_EN
   logic [4:0]       popcnt_s;
   logic [CNT_W+4:0] bit_sum_s;
   logic [CNT_W+3:0] bit_error_count_q, bit_error_count_d;

   prbs_popcount16 u_popcount (
      .data_i  (data_in ^ expected_s),
      .count_o (popcnt_s)
   );

   // One extra sum bit exposes overflow so the counter can clamp to all-ones.
   assign bit_sum_s = {1'b0, bit_error_count_q} + {{CNT_W{1'b0}}, popcnt_s};

   // Bit error counter: clear wins, otherwise accumulate while LOCKED.
   always_comb begin
      bit_error_count_d = bit_error_count_q;
      if (clear_counts) begin
         bit_error_count_d = {(CNT_W+4){1'b0}};
      end else if (locked_beat_s) begin
         if (bit_sum_s[CNT_W+4]) begin
            bit_error_count_d = {(CNT_W+4){1'b1}};
         end else begin
            bit_error_count_d = bit_sum_s[CNT_W+3:0];
         end
      end else begin
         bit_error_count_d = bit_error_count_q;
      end
   end

   // Bit error counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_error_count_q <= {(CNT_W+4){1'b0}};
      end else begin
         bit_error_count_q <= bit_error_count_d;
      end
   end

   assign bit_error_count = bit_error_count_q;
`else
   logic unused_locked_beat_s;
   assign unused_locked_beat_s = locked_beat_s;
`endif

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side checker for the 16-bit Fibonacci LFSR stream produced by the team's random/PRBS generator.
  - Generator update: next = {cur[14:0], cur[15]^cur[14]}, one word per valid beat.
- Self-synchronises by seeding from the incoming words, then free-runs its own prediction (flywheel) and compares every valid word.
- Reports lock status, a per-word error pulse and a saturating error count. Used at link/loopback endpoints and in verification harnesses.

Parameters:
- LOCK_CNT, 4, consecutive correctly-predicted words in HUNT required to declare lock (1..15)
- UNLOCK_CNT, 8, consecutive mismatches in LOCKED that drop lock (1..15)
- CNT_W, 16, width of error_count (saturating)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- data_valid  in  1  data_in is a valid stream word this cycle
- data_in  in  16  received LFSR word
- clear_counts  in  1  synchronous clear of error_count
- locked  out  1  checker is locked to the stream
- error_flag  out  1  one-cycle pulse: previous valid word mismatched while LOCKED
- error_count  out  CNT_W  mismatched words counted while LOCKED, saturates at all-ones

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clk and reset.
- All outputs are registered, with latency 1 cycle from the data_valid beat.
- Reset values:
  - locked=0, error_flag=0, error_count=0.
  - Internal: state=HUNT, ref=0, ref_valid=0, match_run=0, miss_run=0.
- Reset asserted mid-stream forces these values on the next edge. No beat is processed in a reset cycle.
- data_valid=0: all state holds, error_flag=0 the next cycle.
- HUNT state, per valid beat (outputs locked=0, error_flag never set, error_count never increments):
  - data_in==0: illegal LFSR state. Set ref_valid=0 and match_run=0.
  - Otherwise, if ref_valid and data_in==next(ref): match_run++. Else match_run=0.
  - In either non-zero case: ref<=data_in, ref_valid<=1.
  - When the increment makes match_run==LOCK_CNT: state<=LOCKED, miss_run<=0, and locked=1 from the next cycle.
- LOCKED state, per valid beat:
  - expected=next(ref); ref<=expected (flywheel: ref never reloads from data_in).
  - data_in==expected: miss_run=0.
  - Else: error_flag=1 next cycle, error_count+1 (saturating at 2^CNT_W-1), miss_run++.
  - When miss_run reaches UNLOCK_CNT: state<=HUNT, ref_valid<=0, match_run<=0, locked=0 next cycle. The mismatch that causes unlock is still counted and flagged.
- Simultaneous events:
  - clear_counts with an increment: clear wins, count=0.
  - clear_counts does not affect lock state, ref, or the run counters.
- next() is purely combinational, 16 bits. Bit slip in the stream shows as persistent mismatch and leads to unlock and re-hunt.

Optional Feature:
- Macro: PRBS_CHECKER_BITERR_EN.
- Defined:
  - Adds output bit_error_count (out, CNT_W+4 bits, reset 0).
  - In LOCKED it accumulates popcount(data_in ^ expected) per valid beat and saturates at all-ones.
  - clear_counts clears it with the same clear-wins rule.
- Undefined: the port and its logic are absent, and word-level behaviour is identical.

Decomposition:
- Package prbs_pkg holds:
  - PRBS_W=16 and the tap positions (15,14).
  - Function lfsr_next(word).
  - Enum checker_state_t {HUNT, LOCKED}.
- The generator also uses prbs_pkg.
- One sub-module: prbs_popcount16 (combinational 16-bit popcount), instantiated only under PRBS_CHECKER_BITERR_EN.

Test Plan:
- Lock acquisition: reset, then feed the generator sequence from seed 16'hACE1 (second word 16'h59C3), one per cycle → locked rises the cycle after the 5th valid word (LOCK_CNT=4), error_count stays 0.
- Single error: locked, corrupt one word (XOR 16'h0001) → error_flag high exactly one cycle after it, error_count=1. The next clean word matches (flywheel) and locked stays 1.
- Loss of lock: locked, then 8 consecutive words of 16'h1234 → error_count=8, locked=0 after the 8th. Resume the clean sequence → relock after 5 words, count held at 8.
- Gaps and zeros: in HUNT, valid words interleaved with data_valid=0 idles still lock after 5 valid words. All-zero words in HUNT never lock.
- Counters: clear_counts asserted in the same cycle as a mismatch → error_count=0, and locked is unchanged. With CNT_W=4, 20 errors → count saturates at 15.
- Reset mid-stream while locked with error_count=3 → next cycle locked=0, error_count=0, error_flag=0.
